rtc_timekeeper: RTL and testbench
=================================

RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per one-second tick.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink half-period.
REQ-003 SHALL have parameter HOLD_CYC, default 50000000, meaning clk cycles of forced-visible display after any edit increment.
REQ-004 SHALL have parameter REPEAT_DLY, default 25000000, meaning btn_inc hold cycles before auto-repeat starts.
REQ-005 SHALL have parameter REPEAT_PER, default 5000000, meaning clk cycles between auto-repeat increments.
REQ-006 SHALL have parameter HOURS, default 24, meaning hour modulus (legal values 12 or 24).
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is synchronous to its rising edge.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have ports btn_run, btn_sel and btn_inc, each input, 1 bit, raw asynchronous buttons, active-low (pressed = 0).
REQ-010 SHALL have ports sec and min, each output, 6 bits, binary seconds and minutes 0..59.
REQ-011 SHALL have port hour, output, 5 bits, binary hour 0..HOURS-1.
REQ-012 SHALL have port running, output, 1 bit, 1 = time advancing, 0 = edit mode.
REQ-013 SHALL have port sel, output, 3 bits, selected edit field.
REQ-014 SHALL have port blank, output, 5 bits, one-hot display blanking per field (bit index = sel code).
REQ-015 SHALL have port alarm_hit, output, 1 bit, present only with RTC_ALARM_EN.

Function
REQ-016 SHALL pass each button through a two-flop synchroniser, then generate a 1-cycle press pulse on the synchronised 0->1 transition of pressed.
REQ-017 SHALL run a prescaler 0..TICK_DIV-1 while running=1, emitting tick when count==TICK_DIV-1, and hold it at 0 while running=0.
REQ-018 SHALL advance time on tick: sec wraps 59->0 with carry to min; min wraps 59->0 with carry to hour; hour wraps HOURS-1->0.
REQ-019 SHALL toggle running on each btn_run press, with all fields preserved.
REQ-020 SHALL cycle sel on each btn_sel press as 0 sec -> 1 min -> 2 hour -> 0 (alarm codes per REQ-031), in either mode.
REQ-021 SHALL, on a btn_inc press with running=0, increment only the selected field modulo its limit, with no carry.
REQ-022 SHALL ignore btn_inc while running=1.
REQ-023 SHALL, after btn_inc has been held continuously for REPEAT_DLY cycles following the press, produce one extra increment, then one every REPEAT_PER cycles until release.
REQ-024 SHALL, on simultaneous press events in one cycle, apply inc using the pre-update running and sel values.
REQ-025 SHALL toggle a blink phase every BLINK_DIV cycles; blank[sel] = phase only when running=0 and the hold-off counter is 0; all other blank bits = 0.
REQ-026 SHALL reload the hold-off counter to HOLD_CYC on every edit increment and decrement it to 0 once per clk.

Reset
REQ-027 SHALL, with reset=0, asynchronously force: sec=min=hour=0, running=1, sel=0, blank=0, prescaler, blink, hold-off and repeat counters 0, synchronisers to not-pressed, alarm registers 0, alarm_hit=0.
REQ-028 SHALL, on reset release mid-hold, generate no press pulse until the button is released and pressed again.

Configuration
REQ-029 SHALL compile the alarm feature only under macro RTC_ALARM_EN.
REQ-030 SHALL, with RTC_ALARM_EN defined, add registers al_min (6 bits) and al_hour (5 bits).
REQ-031 SHALL, with RTC_ALARM_EN defined, extend the sel cycle to 0..4 (3 = alarm minute, 4 = alarm hour), editable like the other fields.
REQ-032 SHALL, with RTC_ALARM_EN defined, assert alarm_hit while running=1, hour==al_hour and min==al_min.
REQ-033 SHALL, without RTC_ALARM_EN, have sel cycle 0..2, blank[4:3]=0, and no alarm_hit port.

Structure
REQ-034 SHALL take from shared package rtc_pkg: field codes SEL_SEC/SEL_MIN/SEL_HOUR/SEL_AMIN/SEL_AHOUR, SEC_MAX=59, MIN_MAX=59, and field widths.
REQ-035 SHALL implement synchronise, edge detect and auto-repeat in sub-module btn_conditioner, instantiated three times; repeat is used only for inc.

Verification (TICK_DIV=4, BLINK_DIV=8, HOLD_CYC=20, REPEAT_DLY=10, REPEAT_PER=3, HOURS=24)
REQ-036 SHALL cover rollover: preset 23:59:59 running, one tick -> 00:00:00 in the same cycle as tick.
REQ-037 SHALL cover edit: stop, sel to hour, btn_inc press at hour=23 -> hour=0, min and sec unchanged.
REQ-038 SHALL cover repeat: stopped, sel=sec, hold btn_inc 20 cycles after sync -> sec=+1 at press, +1 at cycle 10, +1 at cycles 13, 16, 19 (total 5).
REQ-039 SHALL cover blink: stopped, no edits for 40 cycles -> blank[sel] toggles every 8 cycles; one inc -> blank=0 for 20 cycles.
REQ-040 SHALL cover simultaneous presses: btn_run and btn_inc pressed in the same cycle while running -> running=0, no increment.
REQ-041 SHALL cover the alarm (RTC_ALARM_EN): al_hour=0, al_min=1, run from 00:00:59 -> alarm_hit rises at 00:01:00 and falls at 00:02:00.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared field codes, widths and helpers for the RTC timekeeper.
// RTC_ALARM_EN extends the edit-field cycle with the alarm minute/hour codes.
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int SEL_W   = 3;
  localparam int BLANK_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [SEL_W-1:0] {
    SEL_SEC   = 3'd0,
    SEL_MIN   = 3'd1,
    SEL_HOUR  = 3'd2,
    SEL_AMIN  = 3'd3,
    SEL_AHOUR = 3'd4
  } sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } mode_e;

`ifdef RTC_ALARM_EN
  localparam sel_e SEL_LAST = SEL_AHOUR;
`else
  localparam sel_e SEL_LAST = SEL_HOUR;
`endif

  function automatic sel_e sel_next(input sel_e s);
    return (s == SEL_LAST) ? SEL_SEC : sel_e'(s + 3'd1);
  endfunction

  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Active-low button: two-flop synchroniser, press pulse, optional hold-to-repeat.
// No pulse is produced for a button already held when reset releases.
module btn_conditioner #(
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic evt_o
);

  logic sync1_q, sync2_q;
  logic vld1_q, vld2_q;
  logic armed_q, prev_q;
  logic pressed, press;

  assign pressed = ~sync2_q;
  assign press   = armed_q & pressed & ~prev_q;

  // vld marks when sync2 holds a real sample; armed needs a real release first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      prev_q  <= pressed;
      if (vld2_q && !pressed) armed_q <= 1'b1;
    end
  end

  if (REPEAT_EN) begin : g_rpt
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic             rpt;

    always_comb begin
      cnt_d = cnt_q;
      act_d = act_q;
      if (press) begin
        act_d = 1'b1;
        cnt_d = RPT_W'(REPEAT_DLY - 1);
      end else if (!pressed) begin
        act_d = 1'b0;
      end else if (act_q) begin
        cnt_d = (cnt_q == '0) ? RPT_W'(REPEAT_PER - 1) : cnt_q - RPT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        act_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        act_q <= act_d;
      end
    end

    assign rpt   = act_q & pressed & (cnt_q == '0);
    assign evt_o = press | rpt;
  end else begin : g_norpt
    assign evt_o = press;
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Real-time clock with run/edit modes, button editing, auto-repeat and blinking field.
// Define RTC_ALARM_EN to add the alarm minute/hour fields and the alarm_hit output.
//
// state   | meaning
// ST_RUN  | prescaler ticks advance time, btn_inc ignored
// ST_EDIT | time frozen, btn_inc edits the selected field, selected field blinks
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int BLINK_DIV  = 25000000,
  parameter int HOLD_CYC   = 50000000,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int HOURS      = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_sel,
  input  logic               btn_inc,
  output logic [SEC_W-1:0]   sec,
  output logic [MIN_W-1:0]   min,
  output logic [HOUR_W-1:0]  hour,
  output logic               running,
  output logic [SEL_W-1:0]   sel,
  output logic [BLANK_W-1:0] blank
`ifdef RTC_ALARM_EN
  ,
  output logic               alarm_hit
`endif
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS - 1);

  logic run_p, sel_p, inc_evt, edit_inc, tick;
  mode_e mode_q, mode_d;
  sel_e  sel_q, sel_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic [HOUR_W-1:0]  hour_q, hour_d;
  logic [TICK_W-1:0]  pre_q, pre_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  btn_conditioner #(.REPEAT_EN(1'b0)) u_btn_run (
    .clk(clk), .reset(reset), .btn_i(btn_run), .evt_o(run_p)
  );
  btn_conditioner #(.REPEAT_EN(1'b0)) u_btn_sel (
    .clk(clk), .reset(reset), .btn_i(btn_sel), .evt_o(sel_p)
  );
  btn_conditioner #(
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1)
  ) u_btn_inc (
    .clk(clk), .reset(reset), .btn_i(btn_inc), .evt_o(inc_evt)
  );

  assign running  = (mode_q == ST_RUN);
  assign sel      = sel_q;
  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign edit_inc = inc_evt & ~running;
  assign tick     = running && (pre_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      ST_RUN:  if (run_p) mode_d = ST_EDIT;
      ST_EDIT: if (run_p) mode_d = ST_RUN;
      default: mode_d = ST_RUN;
    endcase
  end

  always_comb begin
    sel_d   = sel_p ? sel_next(sel_q) : sel_q;
    pre_d   = (running && !tick) ? pre_q + TICK_W'(1) : '0;
    bcnt_d  = (bcnt_q == BLINK_W'(BLINK_DIV - 1)) ? '0 : bcnt_q + BLINK_W'(1);
    phase_d = (bcnt_q == BLINK_W'(BLINK_DIV - 1)) ? ~phase_q : phase_q;
    hold_d  = edit_inc ? HOLD_W'(HOLD_CYC) : ((hold_q != '0) ? hold_q - HOLD_W'(1) : '0);
  end

  // Ticks carry through all fields; edits touch only the selected field.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (tick) begin
      if (sec_q == SEC_MAX) begin
        sec_d = '0;
        if (min_q == MIN_MAX) begin
          min_d  = '0;
          hour_d = (hour_q >= HOUR_LAST) ? '0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (edit_inc) begin
      case (sel_q)
        SEL_SEC:  sec_d  = inc_wrap6(sec_q, SEC_MAX);
        SEL_MIN:  min_d  = inc_wrap6(min_q, MIN_MAX);
        SEL_HOUR: hour_d = (hour_q >= HOUR_LAST) ? '0 : hour_q + 5'd1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= ST_RUN;
      sel_q   <= SEL_SEC;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      pre_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      pre_q   <= pre_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    blank = '0;
    if (!running && hold_q == '0) blank[sel_q] = phase_q;
  end

`ifdef RTC_ALARM_EN
  logic [MIN_W-1:0]  al_min_q, al_min_d;
  logic [HOUR_W-1:0] al_hour_q, al_hour_d;

  always_comb begin
    al_min_d  = al_min_q;
    al_hour_d = al_hour_q;
    if (edit_inc) begin
      case (sel_q)
        SEL_AMIN:  al_min_d  = inc_wrap6(al_min_q, MIN_MAX);
        SEL_AHOUR: al_hour_d = (al_hour_q >= HOUR_LAST) ? '0 : al_hour_q + 5'd1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      al_min_q  <= '0;
      al_hour_q <= '0;
    end else begin
      al_min_q  <= al_min_d;
      al_hour_q <= al_hour_d;
    end
  end

  assign alarm_hit = running && (hour_q == al_hour_q) && (min_q == al_min_q);
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: arithmetic time model plus directed scenarios.
// Alarm scenario compiled only with RTC_ALARM_EN.
module tb_rtc_timekeeper;

  localparam int TD = 4, BD = 8, HC = 20, RD = 10, RP = 3, HRS = 24;
`ifdef RTC_ALARM_EN
  localparam int NSEL = 5;
`else
  localparam int NSEL = 3;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic b_run = 1'b1, b_sel = 1'b1, b_inc = 1'b1;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       running;
  logic [2:0] sel;
  logic [4:0] blank;
`ifdef RTC_ALARM_EN
  logic       alarm_hit;
`endif

  int n_cmp = 0, n_mis = 0;
  bit chk_en = 1'b0;

  rtc_timekeeper #(
    .TICK_DIV(TD), .BLINK_DIV(BD), .HOLD_CYC(HC),
    .REPEAT_DLY(RD), .REPEAT_PER(RP), .HOURS(HRS)
  ) dut (
    .clk(clk), .reset(rst_n),
    .btn_run(b_run), .btn_sel(b_sel), .btn_inc(b_inc),
    .sec(sec), .min(min), .hour(hour),
    .running(running), .sel(sel), .blank(blank)
`ifdef RTC_ALARM_EN
    , .alarm_hit(alarm_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Model: edge count since reset, per-button pressed history, clock fields as integers.
  int  n, t, held[3];
  int  m_sec, m_min, m_hour, m_sel, rc, last_inc, am, ah;
  bit  armed[3], hist[3][8], ev[3];
  bit  m_run, have_inc, rep, tick, p;

  task automatic mdl_reset();
    n = 0; m_sec = 0; m_min = 0; m_hour = 0; m_sel = 0; m_run = 1'b1;
    rc = 0; have_inc = 1'b0; last_inc = 0; am = 0; ah = 0;
    for (int b = 0; b < 3; b++) begin held[b] = 0; armed[b] = 1'b0; end
  endtask

  function automatic int exp_blank();
    if (m_run || (have_inc && (n - last_inc) < HC)) return 0;
    return ((n / BD) % 2) << m_sel;
  endfunction

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl_reset();
      else begin
        n++;
        hist[0][n % 8] = !b_run;
        hist[1][n % 8] = !b_sel;
        hist[2][n % 8] = !b_inc;
        ev = '{default: 1'b0};
        rep = 1'b0;
        // button seen by the logic at edge n is the raw level sampled two edges earlier
        if (n >= 3) begin
          for (int b = 0; b < 3; b++) begin
            p = hist[b][(n - 2) % 8];
            if (!p) begin
              held[b] = 0;
              armed[b] = 1'b1;
            end else begin
              held[b]++;
              if (armed[b] && held[b] == 1) ev[b] = 1'b1;
              if (armed[b] && b == 2 && held[b] - 1 >= RD && (held[b] - 1 - RD) % RP == 0)
                rep = 1'b1;
            end
          end
        end
        tick = m_run && (rc % TD == TD - 1);
        rc = m_run ? rc + 1 : 0;
        if (tick) begin
          t = (m_hour * 3600 + m_min * 60 + m_sec + 1) % (HRS * 3600);
          m_hour = t / 3600; m_min = (t / 60) % 60; m_sec = t % 60;
        end
        if ((ev[2] || rep) && !m_run) begin
          case (m_sel)
            0: m_sec  = (m_sec + 1) % 60;
            1: m_min  = (m_min + 1) % 60;
            2: m_hour = (m_hour + 1) % HRS;
            3: am     = (am + 1) % 60;
            4: ah     = (ah + 1) % HRS;
            default: ;
          endcase
          have_inc = 1'b1;
          last_inc = n;
        end
        if (ev[0]) m_run = !m_run;
        if (ev[1]) m_sel = (m_sel + 1) % NSEL;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      chk("sec", sec, m_sec);
      chk("min", min, m_min);
      chk("hour", hour, m_hour);
      chk("running", running, m_run);
      chk("sel", sel, m_sel);
      chk("blank", blank, exp_blank());
`ifdef RTC_ALARM_EN
      chk("alarm_hit", alarm_hit, int'(m_run && m_hour == ah && m_min == am));
`endif
    end
  end

  task automatic set_btn(input int b, input logic v);
    if (b == 0) b_run = v;
    else if (b == 1) b_sel = v;
    else b_inc = v;
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b0);
    repeat (3) @(negedge clk);
    set_btn(b, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int s0, cnt, nz;
    logic [4:0] pb;

    repeat (3) @(negedge clk);
    chk("rst_sec", sec, 0);
    chk("rst_min", min, 0);
    chk("rst_hour", hour, 0);
    chk("rst_running", running, 1);
    chk("rst_sel", sel, 0);
    chk("rst_blank", blank, 0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    press(0);
    chk("stop_running", running, 0);
    repeat ((59 - m_sec + 60) % 60) press(2);
    press(1);
    repeat ((59 - m_min + 60) % 60) press(2);
    press(1);
    repeat ((23 - m_hour + 24) % 24) press(2);
    chk("preset_sec", sec, 59);
    chk("preset_min", min, 59);
    chk("preset_hour", hour, 23);
    chk("preset_sel", sel, 2);

    press(2);
    chk("edit_hour_wrap", hour, 0);
    chk("edit_min_kept", min, 59);
    chk("edit_sec_kept", sec, 59);
    repeat (23) press(2);
    press(1);
    chk("sel_back_to_sec", sel, 0);

    press(0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hour == 5'd0) begin found = 1'b1; break; end
    end
    chk("rollover_seen", found, 1);
    chk("rollover_min", min, 0);
    chk("rollover_sec", sec, 0);
    repeat (10) @(negedge clk);

    b_run = 1'b0; b_inc = 1'b0;
    repeat (3) @(negedge clk);
    b_run = 1'b1; b_inc = 1'b1;
    repeat (3) @(negedge clk);
    chk("simul_running", running, 0);

    s0 = m_sec;
    b_inc = 1'b0;
    repeat (20) @(negedge clk);
    b_inc = 1'b1;
    repeat (4) @(negedge clk);
    chk("repeat_sec_plus5", sec, (s0 + 5) % 60);

    repeat (25) @(negedge clk);
    pb = blank; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (blank != pb) cnt++;
      pb = blank;
    end
    chk("blink_toggles_40cyc", cnt, 5);

    s0 = m_sec;
    b_inc = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int'(sec) != s0) begin found = 1'b1; break; end
    end
    chk("holdoff_inc_seen", found, 1);
    nz = 0;
    for (int j = 0; j < 19; j++) begin
      if (j == 1) b_inc = 1'b1;
      @(negedge clk);
      if (blank != 5'd0) nz++;
    end
    chk("holdoff_blank_zero", nz, 0);
    repeat (10) @(negedge clk);

    press(1);
    chk("sel_next", sel, 1);
    repeat (NSEL - 1) press(1);
    chk("sel_wrap", sel, 0);

    b_run = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_hold_no_toggle", running, 1);
    b_run = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_release_no_toggle", running, 1);
    press(0);
    chk("rst_then_press", running, 0);

`ifdef RTC_ALARM_EN
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(0);
    repeat (3) press(1);
    press(2);
    repeat (2) press(1);
    repeat ((59 - m_sec + 60) % 60) press(2);
    chk("al_preset_sec", sec, 59);
    press(0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (alarm_hit) begin found = 1'b1; break; end
    end
    chk("alarm_rise_seen", found, 1);
    chk("alarm_rise_min", min, 1);
    chk("alarm_rise_sec", sec, 0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!alarm_hit) begin found = 1'b1; break; end
    end
    chk("alarm_fall_seen", found, 1);
    chk("alarm_fall_min", min, 2);
    chk("alarm_fall_sec", sec, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
